// File: rtl/tick_sched_pkg.sv
// Shared encodings and helpers for the tick scheduler.
// Channel FSM states, config FSM states and a width helper.
package tick_sched_pkg;

  typedef enum logic [1:0] {
    CH_OFF   = 2'd0,
    CH_ARMED = 2'd1,
    CH_RUN   = 2'd2
  } ch_state_t;

  typedef enum logic {
    CFG_IDLE  = 1'b0,
    CFG_APPLY = 1'b1
  } cfg_state_t;

  // Never returns 0 so a single-entry select still has one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing the shared base tick.
// Wraps from CLK_FREQ/BASE_FREQ-1 to 0; base_tick marks the last count.
module tick_prescaler
  import tick_sched_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BASE_FREQ = 1000
) (
  input  logic clk100MHz,
  input  logic rst,
  output logic base_tick
);

  localparam int P = CLK_FREQ / BASE_FREQ;
  localparam int W = clog2(P);
  localparam logic [W-1:0] LAST = W'(P - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign base_tick = (cnt == LAST);

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel tick scheduler driven by one base-tick prescaler.
// Define TICK_SCHED_ACK_EN for held ticks with tick_ack/overrun ports.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BASE_FREQ = 1000,
  parameter int N_CH      = 4,
  parameter int DIV_W     = 16
) (
  input  logic                     clk100MHz,
  input  logic                     rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [clog2(N_CH)-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]         cfg_div,
`ifdef TICK_SCHED_ACK_EN
  input  logic [N_CH-1:0]          tick_ack,
  output logic [N_CH-1:0]          overrun,
`endif
  output logic [N_CH-1:0]          tick_out,
  output logic [N_CH-1:0]          ch_active
);

  localparam int CH_W = clog2(N_CH);

  logic             base_tick;
  cfg_state_t       cfg_st;
  cfg_state_t       cfg_nxt;
  logic             live;
  logic             accept;
  logic [CH_W-1:0]  cap_ch;
  logic [DIV_W-1:0] cap_div;

  ch_state_t        st      [N_CH];
  ch_state_t        st_nxt  [N_CH];
  logic [DIV_W-1:0] div     [N_CH];
  logic [DIV_W-1:0] div_nxt [N_CH];
  logic [DIV_W-1:0] cnt     [N_CH];
  logic [DIV_W-1:0] cnt_nxt [N_CH];
  logic [N_CH-1:0]  hit;
  logic [N_CH-1:0]  term;
  logic [N_CH-1:0]  tick_q;

  tick_prescaler #(
    .CLK_FREQ  (CLK_FREQ),
    .BASE_FREQ (BASE_FREQ)
  ) u_pre (
    .clk100MHz (clk100MHz),
    .rst       (rst),
    .base_tick (base_tick)
  );

  assign accept = cfg_valid & cfg_ready;

  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      cfg_st  <= CFG_IDLE;
      live    <= 1'b0;
      cap_ch  <= '0;
      cap_div <= '0;
    end else begin
      cfg_st <= cfg_nxt;
      live   <= 1'b1;
      if (accept) begin
        cap_ch  <= cfg_ch;
        cap_div <= cfg_div;
      end
    end
  end

  always_comb begin
    cfg_nxt = cfg_st;
    unique case (cfg_st)
      CFG_IDLE:  if (accept) cfg_nxt = CFG_APPLY;
      CFG_APPLY: cfg_nxt = CFG_IDLE;
      default:   cfg_nxt = CFG_IDLE;
    endcase
  end

  // live holds ready low until the first clock out of reset
  always_comb begin
    cfg_ready = 1'b0;
    if (cfg_st == CFG_IDLE) cfg_ready = live;
  end

  always_comb begin
    hit     = '0;
    term    = '0;
    st_nxt  = st;
    cnt_nxt = cnt;
    div_nxt = div;
    for (int i = 0; i < N_CH; i++) begin
      hit[i]  = (cfg_st == CFG_APPLY) &&
                (int'(cap_ch) == i);
      term[i] = (st[i] == CH_RUN) && base_tick &&
                (cnt[i] == div[i] - 1'b1);
      if (hit[i]) begin
        div_nxt[i] = cap_div;
        cnt_nxt[i] = '0;
        st_nxt[i]  = (cap_div != '0) ? CH_ARMED
                                     : CH_OFF;
      end else if (base_tick) begin
        unique case (st[i])
          CH_ARMED: begin
            st_nxt[i]  = CH_RUN;
            cnt_nxt[i] = '0;
          end
          CH_RUN:
            cnt_nxt[i] = term[i] ? '0
                                 : cnt[i] + 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        st[i]  <= CH_OFF;
        cnt[i] <= '0;
        div[i] <= '0;
      end
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
      div <= div_nxt;
    end
  end

`ifdef TICK_SCHED_ACK_EN
  logic [N_CH-1:0] ovr_q;

  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      tick_q <= '0;
      ovr_q  <= '0;
    end else begin
      tick_q <= term | (tick_q & ~tick_ack);
      ovr_q  <= (ovr_q | (term & tick_q)) & ~hit;
    end
  end

  assign overrun = ovr_q;
`else
  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst)
      tick_q <= '0;
    else
      tick_q <= term;
  end
`endif

  assign tick_out = tick_q;

  always_comb begin
    ch_active = '0;
    for (int i = 0; i < N_CH; i++)
      ch_active[i] = (st[i] == CH_RUN);
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler (1 kHz clock, 100 Hz base).
// Also covers the TICK_SCHED_ACK_EN build when that macro is defined.
module tb_tick_scheduler;

  localparam int NC = 4;
  localparam int P  = 10;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [3:0] tick_out;
  logic [3:0] ch_active;
`ifdef TICK_SCHED_ACK_EN
  logic [3:0] tick_ack;
  logic [3:0] overrun;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 0;

  tick_scheduler #(
    .CLK_FREQ  (1000),
    .BASE_FREQ (100),
    .N_CH      (NC),
    .DIV_W     (8)
  ) dut (
    .clk100MHz (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
`ifdef TICK_SCHED_ACK_EN
    .tick_ack  (tick_ack),
    .overrun   (overrun),
`endif
    .tick_out  (tick_out),
    .ch_active (ch_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Model: ticks follow global base-tick index arithmetic
  int  t, bidx;
  bit  m_live, m_pend;
  int  p_ch, p_div;
  int  mdiv   [NC];
  int  mstart [NC];
  bit  run    [NC];
  bit  armed  [NC];
  logic [3:0] e_tick, e_ovr, newt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t = 0; bidx = 0; m_live = 0; m_pend = 0;
      e_tick = '0; e_ovr = '0;
      for (int i = 0; i < NC; i++) begin
        mdiv[i] = 0; mstart[i] = 0;
        run[i] = 0; armed[i] = 0;
      end
    end else begin
      bit bt, acc;
      bt  = (t % P) == P - 1;
      acc = m_live && !m_pend && cfg_valid;
      newt = '0;
      if (bt) begin
        for (int i = 0; i < NC; i++) begin
          if (run[i] && bidx > mstart[i] &&
              ((bidx - mstart[i]) % mdiv[i]) == 0)
            newt[i] = 1'b1;
        end
        for (int i = 0; i < NC; i++) begin
          if (armed[i]) begin
            armed[i] = 0; run[i] = 1;
            mstart[i] = bidx;
          end
        end
      end
`ifdef TICK_SCHED_ACK_EN
      e_ovr  = e_ovr | (newt & e_tick);
      e_tick = newt | (e_tick & ~tick_ack);
`else
      e_tick = newt;
`endif
      if (m_pend && p_ch < NC) begin
        mdiv[p_ch]  = p_div;
        run[p_ch]   = 0;
        armed[p_ch] = (p_div != 0);
        e_ovr[p_ch] = 1'b0;
      end
      if (acc) begin
        p_ch = int'(cfg_ch);
        p_div = int'(cfg_div);
      end
      m_pend = acc;
      m_live = 1;
      if (bt) bidx++;
      t++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] e_act;
      for (int i = 0; i < NC; i++) e_act[i] = run[i];
      chk("model_tick_out", 32'(tick_out), 32'(e_tick));
      chk("model_ch_active", 32'(ch_active), 32'(e_act));
      chk("model_cfg_ready", 32'(cfg_ready),
          32'(m_live && !m_pend));
`ifdef TICK_SCHED_ACK_EN
      chk("model_overrun", 32'(overrun), 32'(e_ovr));
`endif
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  int last_bt = -1;
  int nbt     = 0;
  always @(negedge clk) begin
    if (rst) last_bt = -1;
    else if (dut.base_tick) begin
      if (last_bt >= 0 && nbt < 4) begin
        chk("base_tick_period", 32'(cyc - last_bt), 10);
        nbt++;
      end
      last_bt = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_tick(input int ch, input int maxc,
                           output int at);
    at = -1;
    for (int n = 0; n < maxc; n++) begin
      step();
      if (tick_out[ch]) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++; failures++;
      $display("FAIL wait_tick ch%0d: none in %0d cycles",
               ch, maxc);
    end
  endtask

  task automatic wait_active(input int ch, input int maxc,
                             output int at);
    at = -1;
    for (int n = 0; n < maxc; n++) begin
      step();
      if (ch_active[ch]) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++; failures++;
      $display("FAIL wait_active ch%0d: none in %0d cycles",
               ch, maxc);
    end
  endtask

  task automatic cfg(input int ch, input int dv);
    int n;
    n = 0;
    while (!cfg_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) begin
      checks++; failures++;
      $display("FAIL cfg_timeout: ready 0 expected 1");
    end
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_div   = 8'(dv);
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int ta, tb, tc, cnt;
    logic [3:0] rdy;
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch = '0;
    cfg_div = '0;
`ifdef TICK_SCHED_ACK_EN
    tick_ack = 4'hF;
`endif
    repeat (3) @(posedge clk);
    #2;
    chk("rst_cfg_ready", 32'(cfg_ready), 0);
    chk("rst_tick_out", 32'(tick_out), 0);
    chk("rst_ch_active", 32'(ch_active), 0);
    chk_en = 1'b1;
    rst = 1'b0;
    #1;
    chk("ready_before_clk", 32'(cfg_ready), 0);
    step();
    chk("ready_first_clk", 32'(cfg_ready), 1);

    // ch0 div=3: first tick 30 cycles after RUN
    cfg(0, 3);
    wait_active(0, 30, ta);
    wait_tick(0, 40, tb);
    chk("ch0_first_tick", 32'(tb - ta), 30);
    wait_tick(0, 40, tc);
    chk("ch0_period", 32'(tc - tb), 30);

    // back-to-back valid, alternating ready
    cfg_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cfg_ch  = (k % 2 == 0) ? 2'd1 : 2'd3;
      cfg_div = (k % 2 == 0) ? 8'd1 : 8'd9;
      rdy[k]  = cfg_ready;
      step();
    end
    cfg_valid = 1'b0;
    chk("b2b_ready_pattern", 32'(rdy), 32'b0101);
    wait_active(1, 30, ta);
    wait_tick(1, 20, tb);
    chk("ch1_div1_first", 32'(tb - ta), 10);
    wait_tick(1, 20, tc);
    chk("ch1_div1_period", 32'(tc - tb), 10);
    chk("ch3_ignored", 32'(ch_active[3]), 0);

    // APPLY lands on ch0's terminal base tick
    wait_tick(0, 40, ta);
    repeat (28) step();
    cfg_valid = 1'b1;
    cfg_ch = 2'd0;
    cfg_div = 8'd5;
    step();
    cfg_valid = 1'b0;
    step();
    chk("old_tick_on_apply", 32'(tick_out[0]), 1);
    tb = cyc;
    wait_tick(0, 80, tc);
    chk("ch0_div5_first", 32'(tc - tb), 60);
    wait_tick(0, 80, ta);
    chk("ch0_div5_period", 32'(ta - tc), 50);

    // disable running ch1
    cfg(1, 0);
    step();
    chk("ch1_off_active", 32'(ch_active[1]), 0);
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (tick_out[1]) cnt++;
    end
    chk("ch1_off_no_ticks", 32'(cnt), 0);

`ifdef TICK_SCHED_ACK_EN
    tick_ack[2] = 1'b0;
    cfg(2, 1);
    repeat (45) step();
    chk("ch2_overrun_set", 32'(overrun[2]), 1);
    chk("ch2_tick_held", 32'(tick_out[2]), 1);
    cfg(2, 1);
    step();
    chk("ch2_overrun_clear", 32'(overrun[2]), 0);
    tick_ack[2] = 1'b1;
    step();
`endif

    // 1-cycle reset while ch0 is emitting a tick
    wait_tick(0, 80, ta);
    rst = 1'b1;
    #1;
    chk("async_tick_out", 32'(tick_out), 0);
    chk("async_ch_active", 32'(ch_active), 0);
    chk("async_cfg_ready", 32'(cfg_ready), 0);
    step();
    rst = 1'b0;
    #1;
    chk("ready_low_after_rst", 32'(cfg_ready), 0);
    step();
    chk("ready_back_after_rst", 32'(cfg_ready), 1);

    cfg(0, 2);
    wait_active(0, 30, ta);
    wait_tick(0, 40, tb);
    chk("post_rst_div2", 32'(tb - ta), 20);
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BASE_FREQ, default 1000, prescaler base-tick rate in Hz; CLK_FREQ/BASE_FREQ SHALL be an integer of at least 2.
REQ-003 SHALL have parameter N_CH, default 4, number of tick channels (1..8).
REQ-004 SHALL have parameter DIV_W, default 16, width of the per-channel divide ratio.
REQ-005 SHALL have port clk100MHz, input, 1 bit: system clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port cfg_valid, input, 1 bit: configuration request.
REQ-008 SHALL have port cfg_ready, output, 1 bit: configuration accepted when high together with cfg_valid.
REQ-009 SHALL have port cfg_ch, input, clog2(N_CH) bits: target channel.
REQ-010 SHALL have port cfg_div, input, DIV_W bits: base ticks per channel tick; 0 disables the channel.
REQ-011 SHALL have port tick_out, output, N_CH bits: per-channel tick.
REQ-012 SHALL have port ch_active, output, N_CH bits: channel in RUN state.

Function
REQ-013 SHALL generate base_tick, a 1-cycle pulse every CLK_FREQ/BASE_FREQ cycles, from a free-running prescaler that wraps from (CLK_FREQ/BASE_FREQ)-1 to 0.
REQ-014 SHALL run a top configuration FSM with the states IDLE (cfg_ready=1), APPLY (cfg_ready=0, writes div[cfg_ch] and restarts the channel) and back to IDLE, so that one config is accepted at most every 2 cycles.
REQ-015 SHALL capture cfg_ch/cfg_div only on the cycle where cfg_valid&&cfg_ready; cfg_valid SHALL be allowed to drop without effect while cfg_ready is 0.
REQ-016 SHALL run a per-channel FSM with the transitions OFF -> ARMED on APPLY with div!=0, ARMED -> RUN on the next base_tick (counter=0), and any state -> OFF on APPLY with div==0.
REQ-017 SHALL, in RUN, increment the channel counter on each base_tick; when counter==div-1 and base_tick occur together, the counter SHALL wrap to 0 and tick_out[i] SHALL be high for exactly the following cycle.
REQ-018 SHALL make the first tick after entering RUN occur div base_ticks after the ARMED->RUN base_tick.
REQ-019 SHALL treat div==1 as a tick on every base_tick.
REQ-020 SHALL, when APPLY and a terminal count hit the same channel in the same cycle, emit that tick using the old div and then restart the channel in ARMED with the new div.
REQ-021 SHALL leave other channels untouched by an APPLY to channel i.
REQ-022 SHALL ignore a cfg_ch value of N_CH or greater (handshake still completes).

Reset
REQ-023 SHALL, while rst is high, force the prescaler to 0, every counter to 0, all div to 0, every channel to OFF, the top FSM to IDLE, tick_out=0, ch_active=0 and cfg_ready=0.
REQ-024 SHALL drive cfg_ready=1 on the first clock after rst deasserts.
REQ-025 SHALL, on reset mid-operation, abort any APPLY and drop any in-flight tick pulse immediately.

Configuration
REQ-026 SHALL compile in tick acknowledgment when macro TICK_SCHED_ACK_EN is defined: this adds the ports tick_ack (input, N_CH) and overrun (output, N_CH); tick_out[i] then stays high until tick_ack[i]; a new tick arriving while still high SHALL set overrun[i], sticky and cleared by APPLY to channel i or by reset.
REQ-027 SHALL, without TICK_SCHED_ACK_EN, omit tick_ack and overrun and emit tick_out as 1-cycle pulses per REQ-017.

Structure
REQ-028 SHALL place the channel-state encoding (OFF/ARMED/RUN), the config-FSM encoding and the clog2 function in package tick_sched_pkg.
REQ-029 SHALL instantiate the prescaler as sub-module tick_prescaler (parameters CLK_FREQ and BASE_FREQ; ports clk100MHz, rst, base_tick).

Verification
REQ-030 SHALL verify, with CLK_FREQ=1000 and BASE_FREQ=100, that base_tick occurs every 10 cycles and that cfg ch0 div=3 gives tick_out[0] every 30 cycles after ARMED->RUN.
REQ-031 SHALL verify that back-to-back cfg_valid is accepted on alternate cycles only, and that ch1 div=1 ticks on every base_tick.
REQ-032 SHALL verify that an APPLY to ch0 (div=5) on ch0's terminal cycle still emits the old tick and then gives ticks every 50 cycles.
REQ-033 SHALL verify that cfg div=0 on a running channel drops ch_active and never produces tick_out again.
REQ-034 SHALL verify that asserting rst mid-RUN for 1 cycle clears all outputs asynchronously and that cfg_ready returns on the next clock.
REQ-035 SHALL verify, with TICK_SCHED_ACK_EN, that withholding tick_ack[2] across two ticks sets overrun[2], and that an APPLY to ch2 clears it.
